sccb_init_sequencer: RTL
========================

# sccb_init_sequencer

Sequences the camera SCCB write engine through a register-initialisation ROM after reset, then optionally shares the engine with one runtime requester. It fetches 16-bit entries `{reg_addr, reg_data}`, issues one write per entry via a start/done handshake and honours in-table delay and end markers. It reports completion and timeout errors. It sits between the init ROM, the SCCB write engine and game-side camera control logic.

## Interface
- `ROM_AW`, default 8: ROM address width.
- `ROM_DEPTH`, default 76: hard entry limit; the sequence ends after this many entries even without an end marker.
- `CYC_PER_MS`, default 100000: clk cycles per millisecond.
- `POWERUP_MS`, default 2: wait after reset before the first fetch.
- `TIMEOUT_CYC`, default 2000000: maximum cycles from `m_start` to `m_done`.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `rom_addr`  out  ROM_AW  entry index.
- `rom_data`  in  16  entry; synchronous ROM, valid 1 cycle after `rom_addr`.
- `m_start`  out  1  1-cycle pulse that starts one SCCB write.
- `m_reg_addr`  out  8  register address; held stable from `m_start` until `m_done`.
- `m_reg_data`  out  8  register data; held stable from `m_start` until `m_done`.
- `m_done`  in  1  1-cycle pulse at transaction end.
- `wr_req`  in  1  runtime write request; level, held until `wr_ack`.
- `wr_addr`  in  8  runtime register address.
- `wr_data`  in  8  runtime register data.
- `wr_ack`  out  1  1-cycle pulse when the runtime request is issued.
- `wr_done`  out  1  1-cycle pulse when the runtime write completes.
- `init_done`  out  1  sticky; ROM sequence finished.
- `busy`  out  1  high in every state except `S_IDLE`.
- `err_timeout`  out  1  sticky; at least one transaction timed out.

## Operation
- Entry decode:
  - addr 8'hFF: end marker.
  - addr 8'hFE: delay of `data` ms. A delay of 0 ms is a no-op that takes 1 cycle.
  - Any other value: register write.
- States and transitions:
  - `S_POWERUP`: wait `POWERUP_MS*CYC_PER_MS` cycles, then go to `S_FETCH`.
  - `S_FETCH`: drive `rom_addr` and go to `S_ROMWAIT`.
  - `S_ROMWAIT`: 1 cycle, then go to `S_DECODE`.
  - `S_DECODE`:
    - end marker, or index == `ROM_DEPTH`: go to `S_IDLE` and set `init_done`.
    - delay entry: go to `S_DELAY`.
    - write entry: latch addr/data and go to `S_ISSUE`.
  - `S_ISSUE`: pulse `m_start`, then go to `S_WAIT`.
  - `S_WAIT`:
    - on `m_done`: increment index, return to `S_FETCH`, or to `S_IDLE` when in a runtime write.
    - on timeout counter == `TIMEOUT_CYC`: set `err_timeout` and treat as done; the sequence continues.
  - `S_DELAY`: count `data*CYC_PER_MS` cycles, increment index, go to `S_FETCH`.
  - `S_IDLE`: if `wr_req` (runtime feature only), latch `wr_addr`/`wr_data`, pulse `wr_ack`, go to `S_ISSUE` with the runtime flag set.
- Arbitration: runtime requests are never serviced before `init_done`. `wr_req` during init is held pending, not dropped.
- Index width is `ROM_AW+1`, so the index cannot wrap at `ROM_DEPTH = 2^ROM_AW`.
- Delay counter width is 8 + ceil(log2(`CYC_PER_MS`)) + 1 bits; no overflow for `data` = 255.
- A `m_done` outside `S_WAIT` is ignored.

## Timing
- Reset values: `rom_addr` 0, `m_start` 0, `m_reg_addr` 0, `m_reg_data` 0, `wr_ack` 0, `wr_done` 0, `init_done` 0, `busy` 1, `err_timeout` 0. State after reset is `S_POWERUP`.
- Reset asserted mid-transaction forces `S_POWERUP` immediately. The write engine is reset by the same `reset`.
- Fetch to `m_start`: 3 cycles (FETCH, ROMWAIT, DECODE), pulse in the 4th.
- `m_done` to next `m_start`: 4 cycles.
- Runtime path:
  - `wr_ack` in the cycle after `wr_req` is seen in `S_IDLE`.
  - `m_start` the cycle after `wr_ack`.
  - `wr_done` in the cycle after `m_done`, together with the return to `S_IDLE`.
- `m_done` arriving in the same cycle the timeout expires counts as a normal done; `err_timeout` is not set.
- `init_done` rises in the cycle after the terminating `S_DECODE`.

## Configuration
- Macro: `SCCB_RUNTIME_WR_EN`.
- Defined: the runtime write port is active as described above.
- Undefined:
  - `wr_req`, `wr_addr` and `wr_data` are ignored.
  - `wr_ack` and `wr_done` are tied to 0.
  - `S_IDLE` is terminal until reset.
- The ports exist in both builds.

## Test plan
- Basic sequence: `CYC_PER_MS`=10, `POWERUP_MS`=1, ROM {1280, 1204, FFFF}, engine model returns `m_done` 20 cycles after `m_start` -> `m_start` first at cycle 14 after reset release with addr 12/data 80, then 12/04. `init_done` is set after the 2nd done. Exactly 2 starts in total.
- Delay entry: ROM {1280, FE03, 1100, FFFF} -> gap from the 1st `m_done` to the 2nd `m_start` is 30 + 4 + 4 = 38 cycles.
- Depth limit: `ROM_DEPTH`=4 with no end marker -> exactly 4 starts, then `init_done`; `rom_addr` never exceeds 3.
- Timeout: `TIMEOUT_CYC`=50, engine never returns `m_done` for entry 0 -> `err_timeout`=1 at cycle 50 after `m_start`, and entry 1 is still issued.
- Runtime arbitration (with `SCCB_RUNTIME_WR_EN`): `wr_req` with 3A/04 asserted during init -> no `wr_ack` before `init_done`. After it, `wr_ack`, then `m_start` with 3A/04, then `wr_done` one cycle after `m_done`.
- Reset mid-operation: assert `reset` during `S_WAIT` of entry 1 -> all outputs return to reset values and the sequence restarts from entry 0 after power-up.

Source files
------------

// File: rtl/sccb_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sccb_init_sequencer
// Description : Walks the camera register-init ROM after reset and drives
//               the SCCB write engine one entry at a time. Handles in-table
//               delay (addr FE) and end (addr FF) markers, a hard depth limit
//               and per-transaction timeouts. Optionally shares the engine
//               with one runtime requester once init has finished.
// Build macro : SCCB_RUNTIME_WR_EN - enables the runtime write port. When
//               undefined, wr_req/wr_addr/wr_data are ignored, wr_ack and
//               wr_done stay 0 and the idle state is terminal until reset.
// Ports       : clk, reset (async, active-high)
//               rom_addr/rom_data  - synchronous init ROM (1-cycle latency)
//               m_start, m_reg_addr, m_reg_data, m_done - SCCB write engine
//               wr_req, wr_addr, wr_data, wr_ack, wr_done - runtime requester
//               init_done, busy, err_timeout - status
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_init_sequencer #(
  parameter int ROM_AW      = 8,
  parameter int ROM_DEPTH   = 76,
  parameter int CYC_PER_MS  = 100000,
  parameter int POWERUP_MS  = 2,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              m_start,
  output logic [7:0]        m_reg_addr,
  output logic [7:0]        m_reg_data,
  input  logic              m_done,
  input  logic              wr_req,
  input  logic [7:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic              wr_done,
  output logic              init_done,
  output logic              busy,
  output logic              err_timeout
);

`ifdef SCCB_RUNTIME_WR_EN
  localparam bit RT_EN = 1'b1;
`else
  localparam bit RT_EN = 1'b0;
`endif

  // One shared counter serves power-up, delay and timeout; size it for the
  // largest of the three.
  localparam int PU_CYC = POWERUP_MS * CYC_PER_MS;
  localparam int DLY_W  = 8 + $clog2(CYC_PER_MS) + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1) + 1;
  localparam int PU_W   = $clog2(PU_CYC + 1) + 1;
  localparam int CNT_A  = (DLY_W > TO_W) ? DLY_W : TO_W;
  localparam int CNT_W  = (CNT_A > PU_W) ? CNT_A : PU_W;
  localparam int IDX_W  = ROM_AW + 1;

  typedef enum logic [2:0] {
    S_POWERUP = 3'd0,
    S_FETCH   = 3'd1,
    S_ROMWAIT = 3'd2,
    S_DECODE  = 3'd3,
    S_ISSUE   = 3'd4,
    S_WAIT    = 3'd5,
    S_DELAY   = 3'd6,
    S_IDLE    = 3'd7
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [7:0]         addr_n, data_n;
  logic [7:0]         dly_ms, dly_n;
  logic               rt, rt_n;
  logic               init_n, err_n, ack_n, wdone_n;
  logic [CNT_W-1:0]   dly_cyc;

  assign dly_cyc = CNT_W'(dly_ms) * CNT_W'(CYC_PER_MS);

  // Once the index reaches the depth limit the address is parked at 0 so the
  // ROM is never addressed past its last entry; the decode ignores the data.
  assign rom_addr = (idx < IDX_W'(ROM_DEPTH)) ? idx[ROM_AW-1:0] : '0;
  assign m_start  = (state == S_ISSUE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_POWERUP;
      cnt         <= '0;
      idx         <= '0;
      m_reg_addr  <= 8'h00;
      m_reg_data  <= 8'h00;
      dly_ms      <= 8'h00;
      rt          <= 1'b0;
      init_done   <= 1'b0;
      err_timeout <= 1'b0;
      wr_ack      <= 1'b0;
      wr_done     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      m_reg_addr  <= addr_n;
      m_reg_data  <= data_n;
      dly_ms      <= dly_n;
      rt          <= rt_n;
      init_done   <= init_n;
      err_timeout <= err_n;
      wr_ack      <= ack_n;
      wr_done     <= wdone_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    idx_n   = idx;
    addr_n  = m_reg_addr;
    data_n  = m_reg_data;
    dly_n   = dly_ms;
    rt_n    = rt;
    init_n  = init_done;
    err_n   = err_timeout;
    ack_n   = 1'b0;
    wdone_n = 1'b0;
    case (state)
      S_POWERUP: begin
        if (cnt == CNT_W'(PU_CYC - 1)) state_n = S_FETCH;
        else                           cnt_n   = cnt + CNT_W'(1);
      end
      S_FETCH:   state_n = S_ROMWAIT;
      S_ROMWAIT: state_n = S_DECODE;
      S_DECODE: begin
        // Depth limit is checked first: the ROM word at that index is stale.
        if (idx == IDX_W'(ROM_DEPTH) || rom_data[15:8] == 8'hFF) begin
          state_n = S_IDLE;
          init_n  = 1'b1;
        end else if (rom_data[15:8] == 8'hFE) begin
          state_n = S_DELAY;
          dly_n   = rom_data[7:0];
        end else begin
          state_n = S_ISSUE;
          addr_n  = rom_data[15:8];
          data_n  = rom_data[7:0];
        end
      end
      S_ISSUE: begin
        // Counter tracks cycles since m_start, so it is 1 on the first WAIT.
        state_n = S_WAIT;
        cnt_n   = CNT_W'(1);
      end
      S_WAIT: begin
        // m_done wins over a timeout that expires in the same cycle.
        if (m_done || cnt == CNT_W'(TIMEOUT_CYC)) begin
          if (!m_done) err_n = 1'b1;
          if (rt) begin
            state_n = S_IDLE;
            rt_n    = 1'b0;
            wdone_n = 1'b1;
          end else begin
            state_n = S_FETCH;
            idx_n   = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DELAY: begin
        // Lasts dly_cyc+1 cycles, so a 0 ms delay still costs one cycle.
        if (cnt == dly_cyc) begin
          state_n = S_FETCH;
          idx_n   = idx + IDX_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_IDLE: begin
        // A latched runtime request spends one cycle acknowledging before
        // the engine is started.
        if (rt) begin
          state_n = S_ISSUE;
        end else if (RT_EN && init_done && wr_req) begin
          rt_n   = 1'b1;
          ack_n  = 1'b1;
          addr_n = wr_addr;
          data_n = wr_data;
        end
      end
      default: state_n = S_POWERUP;
    endcase
  end

endmodule
`default_nettype wire
